// File: rtl/led_ctrl_pkg.sv
// Shared encodings and sizing helpers for the multi-channel LED controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_ON,
        S_BLK_ON,
        S_BLK_OFF,
        S_BST_ON,
        S_BST_OFF
    } chan_state_e;

    function automatic int calc_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

    // Counter width for a modulo-n counter, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_ctrl_chan.sv
// One LED channel: mode FSM, phase/burst counters, led/busy/done registers.
// LED_CTRL_PWM_EN adds a per-channel duty register gating the on level.
module led_ctrl_chan
    import led_ctrl_pkg::*;
#(
    parameter int C_HALF_TICKS = 50,
    parameter int C_CNT_W      = 8,
    parameter int C_ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               wr,
    input  logic [1:0]         wr_mode,
    input  logic [C_CNT_W-1:0] wr_count,
`ifdef LED_CTRL_PWM_EN
    input  logic [3:0]         wr_duty,
    input  logic [3:0]         pwm_cnt,
`endif
    output logic               led,
    output logic               busy,
    output logic               done
);

    localparam int              PH_W    = cnt_width(C_HALF_TICKS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(C_HALF_TICKS - 1);
    localparam logic            LED_INV = (C_ACTIVE_LOW != 0);

    chan_state_e        state, state_n;
    logic [PH_W-1:0]    ph, ph_n;
    logic [C_CNT_W-1:0] rem, rem_n;
    logic               zero_pend, zero_pend_n;
    logic               done_n;
    logic               lit;
`ifdef LED_CTRL_PWM_EN
    logic [3:0]         duty;
`endif

    always_comb begin
        state_n     = state;
        ph_n        = ph;
        rem_n       = rem;
        done_n      = zero_pend;
        zero_pend_n = 1'b0;
        if (wr) begin
            // A write always wins over a coincident tick.
            ph_n = '0;
            case (mode_e'(wr_mode))
                MODE_ON:    state_n = S_ON;
                MODE_BLINK: state_n = S_BLK_ON;
                MODE_BURST: begin
                    if (wr_count == '0) begin
                        state_n     = S_OFF;
                        zero_pend_n = 1'b1;
                    end else begin
                        state_n = S_BST_ON;
                        rem_n   = wr_count;
                    end
                end
                default:    state_n = S_OFF;
            endcase
        end else if (tick && (state == S_BLK_ON || state == S_BLK_OFF ||
                              state == S_BST_ON || state == S_BST_OFF)) begin
            if (ph != PH_LAST) begin
                ph_n = ph + 1'b1;
            end else begin
                ph_n = '0;
                case (state)
                    S_BLK_ON:  state_n = S_BLK_OFF;
                    S_BLK_OFF: state_n = S_BLK_ON;
                    S_BST_ON: begin
                        state_n = S_BST_OFF;
                        rem_n   = rem - 1'b1;
                    end
                    S_BST_OFF: begin
                        if (rem != '0) begin
                            state_n = S_BST_ON;
                        end else begin
                            state_n = S_OFF;
                            done_n  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        lit = (state == S_ON) || (state == S_BLK_ON) || (state == S_BST_ON);
`ifdef LED_CTRL_PWM_EN
        lit = lit && (pwm_cnt < duty);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            ph        <= '0;
            rem       <= '0;
            zero_pend <= 1'b0;
            led       <= LED_INV;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef LED_CTRL_PWM_EN
            duty      <= 4'd15;
`endif
        end else begin
            state     <= state_n;
            ph        <= ph_n;
            rem       <= rem_n;
            zero_pend <= zero_pend_n;
            // led follows the state one cycle later; busy tracks the new state.
            led       <= lit ^ LED_INV;
            busy      <= (state_n == S_BST_ON) || (state_n == S_BST_OFF);
            done      <= done_n;
`ifdef LED_CTRL_PWM_EN
            if (wr) duty <= wr_duty;
`endif
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller top: shared prescaler, write decode, channel array.
// Define LED_CTRL_PWM_EN to add per-channel 15-step PWM dimming (wr_duty port).
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int C_CLK_FREQ   = 125000000,
    parameter int C_TICK_HZ    = 100,
    parameter int C_HALF_TICKS = 50,
    parameter int C_NUM_LEDS   = 4,
    parameter int C_CNT_W      = 8,
    parameter int C_ACTIVE_LOW = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [cnt_width(C_NUM_LEDS)-1:0]  wr_ch,
    input  logic [1:0]                        wr_mode,
    input  logic [C_CNT_W-1:0]                wr_count,
`ifdef LED_CTRL_PWM_EN
    input  logic [3:0]                        wr_duty,
`endif
    output logic [C_NUM_LEDS-1:0]             led,
    output logic [C_NUM_LEDS-1:0]             busy,
    output logic [C_NUM_LEDS-1:0]             done
);

    localparam int C_DIV = calc_div(C_CLK_FREQ, C_TICK_HZ);
    localparam int PS_W  = cnt_width(C_DIV);
    localparam int CH_W  = cnt_width(C_NUM_LEDS);

    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    assign tick = (ps_cnt == PS_W'(C_DIV - 1));

    // Free-running; writes never realign it, so first phases may be short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ps_cnt <= '0;
        else        ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end

`ifdef LED_CTRL_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
    end
`endif

    for (genvar i = 0; i < C_NUM_LEDS; i++) begin : g_chan
        led_ctrl_chan #(
            .C_HALF_TICKS (C_HALF_TICKS),
            .C_CNT_W      (C_CNT_W),
            .C_ACTIVE_LOW (C_ACTIVE_LOW)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .wr       (wr_en && (wr_ch == CH_W'(i))),
            .wr_mode  (wr_mode),
            .wr_count (wr_count),
`ifdef LED_CTRL_PWM_EN
            .wr_duty  (wr_duty),
            .pwm_cnt  (pwm_cnt),
`endif
            .led      (led[i]),
            .busy     (busy[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: C_DIV=10, C_HALF_TICKS=2 so each full phase is 20 cycles.
module tb_led_ctrl;
    import led_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [1:0] wr_mode = '0;
    logic [7:0] wr_count = '0;
    logic [3:0] led, busy, done;
    // 3-channel instance so that wr_ch=3 addresses no channel
    logic       wr_en3 = 1'b0;
    logic [1:0] wr_ch3 = '0;
    logic [2:0] led3, busy3, done3;
`ifdef LED_CTRL_PWM_EN
    logic [3:0] wr_duty = 4'd15;
`endif

    int total = 0, bad = 0, ecnt = 0, ndone2 = 0;

    always #5 clk = ~clk;

    led_ctrl #(.C_CLK_FREQ(1000), .C_TICK_HZ(100), .C_HALF_TICKS(2),
               .C_NUM_LEDS(4), .C_CNT_W(8), .C_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_count(wr_count),
`ifdef LED_CTRL_PWM_EN
        .wr_duty(wr_duty),
`endif
        .led(led), .busy(busy), .done(done));

    led_ctrl #(.C_CLK_FREQ(1000), .C_TICK_HZ(100), .C_HALF_TICKS(2),
               .C_NUM_LEDS(3), .C_CNT_W(8), .C_ACTIVE_LOW(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_ch(wr_ch3),
        .wr_mode(wr_mode), .wr_count(wr_count),
`ifdef LED_CTRL_PWM_EN
        .wr_duty(wr_duty),
`endif
        .led(led3), .busy(busy3), .done(done3));

    // Edges since reset release; prescaler ticks on edges where ecnt becomes a multiple of 10.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    always @(posedge clk) if (done[2]) ndone2 <= ndone2 + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns on the falling edge just after the write edge k.
    task automatic wr(input int ch, input int mode, input int cnt, input int duty);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_ch    = 2'(ch);
        wr_mode  = 2'(mode);
        wr_count = 8'(cnt);
`ifdef LED_CTRL_PWM_EN
        wr_duty  = 4'(duty);
`endif
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic seglen(input int b, input logic v, output int n);
        n = 0;
        while (led[b] == v && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        repeat (10) @(negedge clk);
        chk("rst_hold_led", led, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        wr(1, MODE_ON, 0, 15);
        chk("on_edge_k", led[1], 0);
        @(negedge clk);
        chk("on_edge_k1", led[1], 1);
        wr(1, MODE_OFF, 0, 15);
        chk("off_edge_k", led[1], 1);
        @(negedge clk);
        chk("off_edge_k1", led[1], 0);

        wr(0, MODE_BLINK, 0, 15);
        @(negedge clk);
        seglen(0, 1'b1, n);
        chk("blk_first_in_11_20", (n >= 11 && n <= 20), 1);
        for (int p = 0; p < 5; p++) begin
            seglen(0, 1'b0, n);
            chk("blk_low", n, 20);
            chk("blk_others_off", led[3:1], 0);
            seglen(0, 1'b1, n);
            chk("blk_high", n, 20);
        end
        wr(0, MODE_OFF, 0, 15);

        wr(2, MODE_BURST, 3, 15);
        chk("bst_busy_start", busy[2], 1);
        @(negedge clk);
        seglen(2, 1'b1, n);
        chk("bst_first_in_11_20", (n >= 11 && n <= 20), 1);
        seglen(2, 1'b0, n);
        chk("bst_low1", n, 20);
        chk("bst_busy_mid", busy[2], 1);
        seglen(2, 1'b1, n);
        chk("bst_high2", n, 20);
        seglen(2, 1'b0, n);
        chk("bst_low2", n, 20);
        seglen(2, 1'b1, n);
        chk("bst_high3", n, 20);
        chk("bst_busy_last", busy[2], 1);
        n = 0;
        while (!done[2] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bst_done_delay", n, 19);
        chk("bst_busy_fall", busy[2], 0);
        @(negedge clk);
        chk("bst_done_1cyc", done[2], 0);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            n += int'(led[2]);
        end
        chk("bst_no_4th_pulse", n, 0);
        chk("bst_done_count", ndone2, 1);

        wr(2, MODE_BURST, 0, 15);
        chk("zero_done_k", done[2], 0);
        @(negedge clk);
        chk("zero_done_k1", done[2], 1);
        chk("zero_led", led[2], 0);
        chk("zero_busy", busy[2], 0);
        @(negedge clk);
        chk("zero_done_end", done[2], 0);

        wr(2, MODE_BURST, 5, 15);
        repeat (30) @(negedge clk);
        chk("abort_busy_before", busy[2], 1);
        wr(2, MODE_OFF, 0, 15);
        chk("abort_busy_drop", busy[2], 0);
        n = 0;
        repeat (150) begin
            @(negedge clk);
            n += int'(led[2]) + int'(busy[2]);
        end
        chk("abort_quiet", n, 0);
        chk("abort_no_done", ndone2, 2);

        // Write lands on a tick edge: that tick must not count.
        while ((ecnt + 2) % 10 != 0) @(negedge clk);
        wr(3, MODE_BLINK, 0, 15);
        @(negedge clk);
        seglen(3, 1'b1, n);
        chk("coll_first_phase", n, 20);
        seglen(3, 1'b0, n);
        chk("coll_second_phase", n, 20);
        wr(3, MODE_OFF, 0, 15);

        @(negedge clk);
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_mode = MODE_ON;
        @(negedge clk);
        wr_en3 = 1'b0;
        @(negedge clk);
        chk("oor_ignored", led3, 0);
        wr_en3 = 1'b1; wr_ch3 = 2'd2;
        @(negedge clk);
        wr_en3 = 1'b0;
        @(negedge clk);
        chk("oor_valid_ch2", led3, 3'b100);

`ifdef LED_CTRL_PWM_EN
        begin
            int duties[3] = '{5, 15, 0};
            int highs[3]  = '{10, 30, 0};
            for (int d = 0; d < 3; d++) begin
                wr(0, MODE_ON, 0, duties[d]);
                @(negedge clk);
                n = 0;
                repeat (30) begin
                    n += int'(led[0]);
                    @(negedge clk);
                end
                chk("pwm_high_count", n, highs[d]);
            end
        end
`endif

        wr(0, MODE_BLINK, 0, 15);
        @(negedge clk);
        chk("pre_async_rst", led[0], 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_led", led, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
